// File: rtl/machine_pkg.sv
// Shared definitions for the JK/D machine sequencer.
//  state_t : sequencer FSM encodings
//  S_W     : width of the machine state vector S
package machine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int S_W = 3;

endpackage

// File: rtl/pattern_shifter.sv
// LEN-bit load / shift-right register. Bit 0 is the serial output, so a
// loaded pattern comes out LSB first, one bit per shift.
//  CLK, RESET : clock, async active-high reset
//  load       : capture din (wins over shift)
//  shift      : shift right by one, zero fill
//  din        : parallel load data
//  sout       : serial out (current bit 0)
module pattern_shifter #(
  parameter int LEN = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           load,
  input  logic           shift,
  input  logic [LEN-1:0] din,
  output logic           sout
);

  logic [LEN-1:0] sr;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)      sr <= '0;
    else if (load)  sr <= din;
    else if (shift) sr <= sr >> 1;
  end

  assign sout = sr[0];

endmodule

// File: rtl/machine_run_ctrl.sv
// Sequencer for the 3-bit JK/D machine: holds it in reset, then shifts a
// LEN-bit pattern into x (LSB first), counting F=1 cycles, recording the
// first hit index and capturing the final S.
//  CLK, RESET           : clock, async active-high reset
//  start, abort         : run request (IDLE only) / synchronous abort
//  pattern              : stimulus, captured on an accepted start
//  m_F, m_S             : machine outputs
//  m_reset, m_x         : registered machine drives
//  busy, done           : CLEAR/RUN indicator, 1-cycle DONE pulse
//  hit_count, first_hit : F=1 count, first hit index (LEN if none)
//  hit_valid, final_S   : hit_count>0, S at the last RUN edge
module machine_run_ctrl
  import machine_pkg::*;
#(
  parameter int LEN = 8,
  parameter int CW  = 4
) (
  input  logic           CLK,
  input  logic           RESET,
  input  logic           start,
  input  logic           abort,
  input  logic [LEN-1:0] pattern,
  input  logic           m_F,
  input  logic [S_W-1:0] m_S,
  output logic           m_reset,
  output logic           m_x,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  hit_count,
  output logic [CW-1:0]  first_hit,
  output logic           hit_valid,
  output logic [S_W-1:0] final_S
);

  state_t        state, nxt;
  logic [CW-1:0] cnt;
  logic          load, shift, sample, clr, last, sout;
  logic          m_reset_d, m_x_d, busy_d, done_d;

  assign last = (cnt == CW'(LEN - 1));

  pattern_shifter #(.LEN(LEN)) u_shift (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (load),
    .shift (shift),
    .din   (pattern),
    .sout  (sout)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= nxt;
  end

  // Outputs are registered, so they are derived from the next state: the
  // machine sees m_reset/m_x for the whole of the cycle they belong to.
  always_comb begin
    nxt    = state;
    load   = 1'b0;
    sample = 1'b0;
    clr    = 1'b0;
    if (abort) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) begin nxt = CLEAR; load = 1'b1; end
        CLEAR: begin nxt = RUN; clr = 1'b1; end
        RUN:   begin sample = 1'b1; if (last) nxt = DONE; end
        DONE:  nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
    // Entering RUN cycle k: present bit k and advance the shifter.
    shift     = (nxt == RUN);
    m_x_d     = (nxt == RUN) ? sout : 1'b0;
    m_reset_d = (nxt != RUN);
    busy_d    = (nxt == CLEAR) || (nxt == RUN);
    done_d    = (nxt == DONE);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_reset <= 1'b1;
      m_x     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      m_reset <= m_reset_d;
      m_x     <= m_x_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Bit counter and results. An aborting edge takes no sample, so partial
  // results reflect only fully completed RUN cycles.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt       <= '0;
      hit_count <= '0;
      first_hit <= CW'(LEN);
      hit_valid <= 1'b0;
      final_S   <= '0;
    end else if (clr) begin
      cnt       <= '0;
      hit_count <= '0;
      first_hit <= CW'(LEN);
      hit_valid <= 1'b0;
    end else if (sample) begin
      if (!last) cnt <= cnt + 1'b1;
      if (m_F) begin
        if (hit_count != '1) hit_count <= hit_count + 1'b1;
        if (!hit_valid)      first_hit <= cnt;
        hit_valid <= 1'b1;
      end
      if (last) final_S <= m_S;
    end
  end

endmodule
